tone_generator: RTL and testbench



---
 rtl/tone_generator.sv | 207 ++++++++++++++++++++
 tb/tb_tone_generator.sv | 415 ++++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/tone_generator.sv
// Buzzer square-wave generator driven by the controller's note/octave request.
// Define TONE_GAP_EN to insert a silent articulation gap between successive notes.

module tone_generator #(
    parameter int unsigned CLK_HZ     = 100_000_000,
    parameter int unsigned GAP_CYCLES = 1_000_000,
    parameter int          CNT_W      = 20
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [3:0] note_in,
    input  logic [1:0] octave_in,
    input  logic       mute,
    output logic       speaker,
    output logic       playing,
    output logic [3:0] cur_note
);

    typedef enum logic [1:0] {
        SILENT = 2'd0,
        TONE   = 2'd1,
        GAP    = 2'd2
    } state_e;

    // Mid-octave half period from a pitch in centi-hertz; the 100 MHz board keeps its tuned table.
    function automatic logic [CNT_W-1:0] half_of(
        input longint unsigned f_centi,
        input longint unsigned tuned
    );
        longint unsigned num;
        longint unsigned q;
        num = 64'(CLK_HZ) * 64'd100;
        if (CLK_HZ == 32'd100_000_000) begin
            q = tuned;
        end else begin
            q = num / (64'd2 * f_centi);
        end
        return q[CNT_W-1:0];
    endfunction

    localparam logic [CNT_W-1:0] H_DO = half_of(64'd26163, 64'd191113);
    localparam logic [CNT_W-1:0] H_RE = half_of(64'd29366, 64'd170265);
    localparam logic [CNT_W-1:0] H_MI = half_of(64'd32963, 64'd151686);
    localparam logic [CNT_W-1:0] H_FA = half_of(64'd34923, 64'd143172);
    localparam logic [CNT_W-1:0] H_SO = half_of(64'd39200, 64'd127551);
    localparam logic [CNT_W-1:0] H_LA = half_of(64'd44000, 64'd113636);
    localparam logic [CNT_W-1:0] H_SI = half_of(64'd49388, 64'd101239);

    logic [3:0]       s_note_q, s_note_d;
    logic [1:0]       s_oct_q, s_oct_d;
    logic [3:0]       p_note_q, p_note_d;
    logic [1:0]       p_oct_q, p_oct_d;
    state_e           state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [CNT_W-1:0] half_q, half_d;
    logic [3:0]       note_q, note_d;
    logic             spk_q, spk_d;
    logic             speaker_q, speaker_d;
    logic [CNT_W-1:0] half_mid;
    logic [CNT_W-1:0] half_new;
    logic             chg;
    logic             start_tone;

`ifdef TONE_GAP_EN
    localparam logic [CNT_W-1:0] GAP_LAST = CNT_W'(GAP_CYCLES - 1);
    logic [CNT_W-1:0] gcnt_q, gcnt_d;
`else
    // Without the gap the parameter has no effect.
    logic unused_gap;
    assign unused_gap = ^GAP_CYCLES;
`endif

    always_comb begin
        s_note_d = note_in[3] ? 4'd0 : note_in;
        s_oct_d  = (octave_in == 2'd3) ? 2'd1 : octave_in;
        p_note_d = s_note_q;
        p_oct_d  = s_oct_q;
        chg      = ({s_oct_q, s_note_q} != {p_oct_q, p_note_q});
    end

    always_comb begin
        half_mid = '0;
        unique case (s_note_q)
            4'd1:    half_mid = H_DO;
            4'd2:    half_mid = H_RE;
            4'd3:    half_mid = H_MI;
            4'd4:    half_mid = H_FA;
            4'd5:    half_mid = H_SO;
            4'd6:    half_mid = H_LA;
            4'd7:    half_mid = H_SI;
            default: half_mid = '0;
        endcase
        half_new = half_mid;
        unique case (1'b1)
            (s_oct_q == 2'd0): half_new = half_mid << 1;
            (s_oct_q == 2'd2): half_new = half_mid >> 1;
            default:           half_new = half_mid;
        endcase
    end

    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        half_d     = half_q;
        note_d     = note_q;
        spk_d      = spk_q;
        start_tone = 1'b0;
`ifdef TONE_GAP_EN
        gcnt_d     = gcnt_q;
`endif
        unique case (state_q)
            SILENT: begin
                if (s_note_q != 4'd0) begin
                    start_tone = 1'b1;
                end
            end
            TONE: begin
                if (chg && (s_note_q == 4'd0)) begin
                    state_d = SILENT;
                    cnt_d   = '0;
                    spk_d   = 1'b0;
                    note_d  = 4'd0;
                end else if (chg) begin
`ifdef TONE_GAP_EN
                    state_d = GAP;
                    gcnt_d  = '0;
                    cnt_d   = '0;
                    spk_d   = 1'b0;
                    note_d  = 4'd0;
`else
                    start_tone = 1'b1;
`endif
                end else if (cnt_q == half_q - CNT_W'(1)) begin
                    cnt_d = '0;
                    spk_d = ~spk_q;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
`ifdef TONE_GAP_EN
            // Changes during the gap only update s_*; whatever is held at the end wins.
            GAP: begin
                if (gcnt_q == GAP_LAST) begin
                    if (s_note_q != 4'd0) begin
                        start_tone = 1'b1;
                    end else begin
                        state_d = SILENT;
                    end
                end else begin
                    gcnt_d = gcnt_q + CNT_W'(1);
                end
            end
`endif
            default: begin
                state_d = SILENT;
                cnt_d   = '0;
                spk_d   = 1'b0;
                note_d  = 4'd0;
            end
        endcase
        if (start_tone) begin
            state_d = TONE;
            cnt_d   = '0;
            spk_d   = 1'b1;
            note_d  = s_note_q;
            half_d  = half_new;
        end
        speaker_d = spk_d & ~mute;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            s_note_q  <= 4'd0;
            s_oct_q   <= 2'd0;
            p_note_q  <= 4'd0;
            p_oct_q   <= 2'd0;
            state_q   <= SILENT;
            cnt_q     <= '0;
            half_q    <= '0;
            note_q    <= 4'd0;
            spk_q     <= 1'b0;
            speaker_q <= 1'b0;
`ifdef TONE_GAP_EN
            gcnt_q    <= '0;
`endif
        end else begin
            s_note_q  <= s_note_d;
            s_oct_q   <= s_oct_d;
            p_note_q  <= p_note_d;
            p_oct_q   <= p_oct_d;
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            half_q    <= half_d;
            note_q    <= note_d;
            spk_q     <= spk_d;
            speaker_q <= speaker_d;
`ifdef TONE_GAP_EN
            gcnt_q    <= gcnt_d;
`endif
        end
    end

    assign speaker  = speaker_q;
    assign playing  = (state_q == TONE);
    assign cur_note = note_q;

endmodule

// File: tb/tb_tone_generator.sv
// Self-checking bench for tone_generator at a 1 MHz clock.
// Expected waveforms come from pitch arithmetic and note start times.

module tb_tone_generator;

    localparam int unsigned CLK_HZ = 1_000_000;
    localparam int unsigned GAP_N  = 50;

    logic       clk = 1'b0;
    logic       reset;
    logic [3:0] note_in;
    logic [1:0] octave_in;
    logic       mute;
    logic       speaker;
    logic       playing;
    logic [3:0] cur_note;

    int vectors = 0;
    int miscompares = 0;
    int cyc = 0;

    tone_generator #(
        .CLK_HZ(CLK_HZ),
        .GAP_CYCLES(GAP_N),
        .CNT_W(20)
    ) dut (
        .clk(clk),
        .reset(reset),
        .note_in(note_in),
        .octave_in(octave_in),
        .mute(mute),
        .speaker(speaker),
        .playing(playing),
        .cur_note(cur_note)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    initial begin
        #3_000_000;
        $display("FAIL watchdog: simulation time limit reached, miscompares=%0d", miscompares);
        $fatal(1, "watchdog");
    end

    // Half period in cycles: floor(CLK / (2 f)), doubled for low octave, halved for high.
    function automatic int ref_half(input int n, input int o);
        real f;
        int  h;
        if (n < 1 || n > 7) return 0;
        case (n)
            1: f = 261.63;
            2: f = 293.66;
            3: f = 329.63;
            4: f = 349.23;
            5: f = 392.00;
            6: f = 440.00;
            default: f = 493.88;
        endcase
        h = int'($floor(real'(CLK_HZ) / (2.0 * f)));
        if (o == 0) h = h * 2;
        else if (o == 2) h = h / 2;
        return h;
    endfunction

    function automatic logic ref_spk(input int c, input int t0, input int half);
        if (c < t0) return 1'b0;
        return (((c - t0) / half) % 2) == 0;
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic apply(input int n, input int o);
        note_in = 4'(n);
        octave_in = 2'(o);
    endtask

    task automatic do_reset();
        reset = 1'b1;
        mute = 1'b0;
        apply(0, 0);
        tick();
        tick();
        reset = 1'b0;
    endtask

    task automatic test_reset();
        reset = 1'b1;
        mute = 1'b0;
        apply(6, 1);
        #1;
        vectors++;
        if ({speaker, playing, cur_note} !== 6'd0) begin
            miscompares++;
            $display("FAIL reset_async: got %b%b %0d want 000", speaker, playing, cur_note);
        end
        tick();
        tick();
        vectors++;
        if ({speaker, playing, cur_note} !== 6'd0) begin
            miscompares++;
            $display("FAIL reset_held: got %b%b %0d want 000", speaker, playing, cur_note);
        end
        reset = 1'b0;
        apply(0, 0);
        tick();
    endtask

    task automatic test_first_tone();
        int a;
        int w;
        do_reset();
        apply(6, 1);
        a = cyc;
        tick();
        vectors++;
        if (speaker !== 1'b0 || playing !== 1'b0) begin
            miscompares++;
            $display("FAIL first_early: spk=%b play=%b want 0 0 at +1", speaker, playing);
        end
        tick();
        vectors++;
        if ({speaker, playing, cur_note} !== {1'b1, 1'b1, 4'd6}) begin
            miscompares++;
            $display("FAIL first_rise: got %b%b %0d want 1 1 6", speaker, playing, cur_note);
        end
        w = 0;
        while (speaker === 1'b1 && w < 5000) begin
            tick();
            w++;
        end
        vectors++;
        if (w !== 1136) begin
            miscompares++;
            $display("FAIL first_high_width: got %0d want 1136", w);
        end
        w = 0;
        while (speaker === 1'b0 && w < 5000) begin
            tick();
            w++;
        end
        vectors++;
        if (w !== 1136) begin
            miscompares++;
            $display("FAIL first_low_width: got %0d want 1136", w);
        end
        for (int i = 0; i < 800; i++) begin
            tick();
            vectors++;
            if ({speaker, playing, cur_note} !==
                {ref_spk(cyc, a + 2, ref_half(6, 1)), 1'b1, 4'd6}) begin
                miscompares++;
                $display("FAIL first_scan: cyc=%0d got %b%b %0d", cyc, speaker, playing, cur_note);
                break;
            end
        end
    endtask

    task automatic test_octaves();
        int exp_w[4];
        int w;
        exp_w = '{3822, 1911, 955, 1911};
        for (int o = 0; o < 4; o++) begin
            do_reset();
            apply(1, o);
            tick();
            tick();
            w = 0;
            while (speaker === 1'b1 && w < 8000) begin
                tick();
                w++;
            end
            vectors++;
            if (w !== exp_w[o]) begin
                miscompares++;
                $display("FAIL octave_%0d_width: got %0d want %0d", o, w, exp_w[o]);
            end
        end
    endtask

    task automatic test_random_notes();
        int n, o, h, t0;
        int no, ho, t0o, hold;
        int n2, len;
        logic [5:0] exp;
        do_reset();
        n = $urandom_range(1, 7);
        o = $urandom_range(0, 3);
        apply(n, o);
        t0 = cyc + 2;
        h = ref_half(n, o);
        hold = -1;
        no = 0; ho = 1; t0o = 0;
        for (int seg = 0; seg < 6; seg++) begin
            len = $urandom_range(h, 2 * h + 5);
            if (len > 3000) len = 3000;
            for (int i = 0; i < len; i++) begin
                tick();
                if (cyc <= hold) exp = {ref_spk(cyc, t0o, ho), 1'b1, 4'(no)};
                else if (cyc < t0) exp = 6'd0;
                else exp = {ref_spk(cyc, t0, h), 1'b1, 4'(n)};
                vectors++;
                if ({speaker, playing, cur_note} !== exp) begin
                    miscompares++;
                    $display("FAIL random_seg%0d: cyc=%0d got %b%b %0d want %b%b %0d",
                             seg, cyc, speaker, playing, cur_note, exp[5], exp[4], exp[3:0]);
                    break;
                end
            end
            n2 = $urandom_range(1, 6);
            if (n2 >= n) n2++;
            no = n; ho = h; t0o = t0;
            hold = cyc + 1;
            n = n2;
            o = $urandom_range(0, 3);
            apply(n, o);
            h = ref_half(n, o);
`ifdef TONE_GAP_EN
            t0 = cyc + 2 + int'(GAP_N);
`else
            t0 = cyc + 2;
`endif
        end
    endtask

    task automatic test_change();
        int a;
        int w;
        do_reset();
        apply(3, 1);
        repeat (40) tick();
        apply(5, 1);
        a = cyc;
        tick();
        vectors++;
        if (playing !== 1'b1 || cur_note !== 4'd3) begin
            miscompares++;
            $display("FAIL change_hold: play=%b note=%0d want 1 3", playing, cur_note);
        end
        tick();
`ifdef TONE_GAP_EN
        w = 0;
        while (playing === 1'b0 && speaker === 1'b0 && cur_note === 4'd0 && w < 200) begin
            tick();
            w++;
        end
        vectors++;
        if (w !== 50) begin
            miscompares++;
            $display("FAIL gap_length: got %0d want 50", w);
        end
`endif
        vectors++;
        if ({speaker, playing, cur_note} !== {1'b1, 1'b1, 4'd5}) begin
            miscompares++;
            $display("FAIL change_start: got %b%b %0d want 1 1 5", speaker, playing, cur_note);
        end
        w = 0;
        while (speaker === 1'b1 && w < 5000) begin
            tick();
            w++;
        end
        vectors++;
        if (w !== 1275) begin
            miscompares++;
            $display("FAIL change_width: got %0d want 1275 (start cyc %0d)", w, a);
        end
    endtask

    task automatic test_rest();
        do_reset();
        apply(4, 1);
        repeat (30) tick();
        apply(0, 1);
        tick();
        vectors++;
        if (playing !== 1'b1) begin
            miscompares++;
            $display("FAIL rest_hold: play=%b want 1", playing);
        end
        tick();
        vectors++;
        if ({speaker, playing, cur_note} !== 6'd0) begin
            miscompares++;
            $display("FAIL rest_stop: got %b%b %0d want 000", speaker, playing, cur_note);
        end
        apply(4, 1);
        repeat (10) tick();
        apply(12, 1);
        tick();
        tick();
        vectors++;
        if ({speaker, playing, cur_note} !== 6'd0) begin
            miscompares++;
            $display("FAIL rest_high_code: got %b%b %0d want 000", speaker, playing, cur_note);
        end
        do_reset();
        apply(9, 2);
        for (int i = 0; i < 300; i++) begin
            tick();
            vectors++;
            if ({speaker, playing, cur_note} !== 6'd0) begin
                miscompares++;
                $display("FAIL note9_silent: cyc=%0d got %b%b %0d", cyc, speaker, playing, cur_note);
                break;
            end
        end
    endtask

    task automatic test_mute();
        int t0, h, m, r;
        logic exp_s;
        do_reset();
        apply(2, 1);
        t0 = cyc + 2;
        h = ref_half(2, 1);
        m = t0 + 500 + int'($urandom_range(0, 1500));
        r = m + 300;
        tick();
        while (cyc < t0 + 4000) begin
            tick();
            exp_s = ref_spk(cyc, t0, h) && !(cyc >= m + 1 && cyc <= r);
            vectors++;
            if ({speaker, playing, cur_note} !== {exp_s, 1'b1, 4'd2}) begin
                miscompares++;
                $display("FAIL mute_scan: cyc=%0d got %b%b %0d want %b 1 2",
                         cyc, speaker, playing, cur_note, exp_s);
                break;
            end
            if (cyc == m) mute = 1'b1;
            if (cyc == r) mute = 1'b0;
        end
        mute = 1'b0;
    endtask

    task automatic test_reset_mid();
        do_reset();
        apply(7, 1);
        repeat (12) tick();
        vectors++;
        if (speaker !== 1'b1) begin
            miscompares++;
            $display("FAIL midreset_pre: spk=%b want 1", speaker);
        end
        #2 reset = 1'b1;
        #1;
        vectors++;
        if ({speaker, playing, cur_note} !== 6'd0) begin
            miscompares++;
            $display("FAIL midreset_tone: got %b%b %0d want 000", speaker, playing, cur_note);
        end
        tick();
        tick();
        reset = 1'b0;
        tick();
        vectors++;
        if (speaker !== 1'b0 || playing !== 1'b0) begin
            miscompares++;
            $display("FAIL midreset_early: spk=%b play=%b want 0 0", speaker, playing);
        end
        tick();
        vectors++;
        if ({speaker, playing, cur_note} !== {1'b1, 1'b1, 4'd7}) begin
            miscompares++;
            $display("FAIL midreset_restart: got %b%b %0d want 1 1 7", speaker, playing, cur_note);
        end
`ifdef TONE_GAP_EN
        apply(2, 1);
        repeat (12) tick();
        vectors++;
        if (playing !== 1'b0) begin
            miscompares++;
            $display("FAIL gapreset_pre: play=%b want 0", playing);
        end
        #2 reset = 1'b1;
        #1;
        vectors++;
        if ({speaker, playing, cur_note} !== 6'd0) begin
            miscompares++;
            $display("FAIL gapreset: got %b%b %0d want 000", speaker, playing, cur_note);
        end
        tick();
        reset = 1'b0;
        tick();
        tick();
        vectors++;
        if ({speaker, playing, cur_note} !== {1'b1, 1'b1, 4'd2}) begin
            miscompares++;
            $display("FAIL gapreset_restart: got %b%b %0d want 1 1 2", speaker, playing, cur_note);
        end
`endif
    endtask

    initial begin
        reset = 1'b1;
        mute = 1'b0;
        note_in = 4'd0;
        octave_in = 2'd0;
        test_reset();
        test_first_tone();
        test_octaves();
        test_change();
        test_rest();
        test_mute();
        test_reset_mid();
        test_random_notes();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
